// File: rtl/ps2_key_encoder.sv
// PS/2 set-2 keyboard receiver and make-code translator for the ALU keypad path.
// Optional: define TYPEMATIC_FILTER_EN to suppress auto-repeat until the key's release.
module ps2_key_encoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int VALID_CYCLES   = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data,
    output logic       validate,
    output logic [7:0] raw_code,
    output logic       frame_err,
    output logic [3:0] debug_state
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int VW = $clog2(VALID_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

    rx_state_t     state;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          bit_val;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_ok;
    logic [TW-1:0] to_cnt;
    logic          rx_done;
    logic          ext_flag;
    logic          brk_flag;
    logic [VW-1:0] v_cnt;
    logic [8:0]    xlat;
    logic          repeat_hit;

    assign debug_state = {ext_flag, brk_flag, state};

    // Synchronizers idle high so release from reset never fakes a falling edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    // The data bit is captured at the moment the filtered clock falls.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
            bit_val  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                if (!clk_sync[1]) begin
                    fall    <= 1'b1;
                    bit_val <= dat_sync[1];
                end
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            par_ok    <= 1'b0;
            to_cnt    <= '0;
            rx_done   <= 1'b0;
            raw_code  <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                // An edge always beats a coincident timeout.
                to_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (!bit_val) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shift   <= {bit_val, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_ok <= ^{shift, bit_val};
                        state  <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (bit_val && par_ok) begin
                            raw_code <= shift;
                            rx_done  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state == S_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= S_IDLE;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    function automatic logic [8:0] translate(input logic [7:0] code);
        case (code)
            8'h45:   return {1'b1, 8'd0};
            8'h16:   return {1'b1, 8'd1};
            8'h1E:   return {1'b1, 8'd2};
            8'h26:   return {1'b1, 8'd3};
            8'h25:   return {1'b1, 8'd4};
            8'h2E:   return {1'b1, 8'd5};
            8'h36:   return {1'b1, 8'd6};
            8'h3D:   return {1'b1, 8'd7};
            8'h3E:   return {1'b1, 8'd8};
            8'h46:   return {1'b1, 8'd9};
            8'h44:   return {1'b1, 8'd18};
            8'h1C:   return {1'b1, 8'd15};
            8'h32:   return {1'b1, 8'd19};
            8'h21:   return {1'b1, 8'd16};
            8'h1B:   return {1'b1, 8'd12};
            8'h79:   return {1'b1, 8'd26};
            8'h7B:   return {1'b1, 8'd30};
            default: return {1'b0, 8'd0};
        endcase
    endfunction

    assign xlat = translate(raw_code);

`ifdef TYPEMATIC_FILTER_EN
    logic [7:0] last_make;
    logic       last_vld;
    assign repeat_hit = last_vld && (last_make == raw_code);
`else
    assign repeat_hit = 1'b0;
`endif

    // Handshake: data changes only in the cycle validate rises, validate stays
    // high VALID_CYCLES cycles, and the consumer latches data on its falling edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            data     <= 8'hFF;
            validate <= 1'b0;
            v_cnt    <= '0;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
            last_make <= '0;
            last_vld  <= 1'b0;
`endif
        end else begin
            if (validate) begin
                if (v_cnt == '0) validate <= 1'b0;
                else             v_cnt    <= v_cnt - 1'b1;
            end
            if (rx_done) begin
                if (raw_code == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (raw_code == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else if (brk_flag) begin
                    brk_flag <= 1'b0;
                    ext_flag <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
                    if (repeat_hit) last_vld <= 1'b0;
`endif
                end else begin
                    ext_flag <= 1'b0;
                    // Overlap with a live pulse can only come from corruption: drop it.
                    if (xlat[8] && !validate && !repeat_hit) begin
                        data     <= xlat[7:0];
                        validate <= 1'b1;
                        v_cnt    <= VW'(VALID_CYCLES - 1);
`ifdef TYPEMATIC_FILTER_EN
                        last_make <= raw_code;
                        last_vld  <= 1'b1;
`endif
                    end
                end
            end
        end
    end

endmodule
